// File: rtl/dt_pkg.sv
// Shared definitions for the multi-block hitbox scanner: scan states,
// coordinate widths and the default hitbox geometry.
package dt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    localparam int XW   = 10;
    localparam int YW   = 9;
    localparam int CMPW = 11;
    localparam int CNTW = 4;

    localparam int DEF_OFS_X = 23;
    localparam int DEF_LO_X  = 2;
    localparam int DEF_HI_X  = 26;
    localparam int DEF_OFS_Y = 41;
    localparam int DEF_TOL_Y = 10;

endpackage

// File: rtl/dt_hit_cmp.sv
// Combinational hitbox test of one player probe point against one block,
// evaluated at CMPW bits so no sum can wrap.
module dt_hit_cmp
    import dt_pkg::*;
#(
    parameter int OFS_X = DEF_OFS_X,
    parameter int LO_X  = DEF_LO_X,
    parameter int HI_X  = DEF_HI_X,
    parameter int OFS_Y = DEF_OFS_Y,
    parameter int TOL_Y = DEF_TOL_Y
) (
    input  logic [XW-1:0] i_xp,
    input  logic [YW-1:0] i_yp,
    input  logic [XW-1:0] i_xb,
    input  logic [YW-1:0] i_yb,
    output logic          o_hit
);

    logic [CMPW-1:0] w_px;
    logic [CMPW-1:0] w_x_lo;
    logic [CMPW-1:0] w_x_hi;
    logic [CMPW-1:0] w_py;
    logic [CMPW-1:0] w_py_hi;
    logic [CMPW-1:0] w_yb;
    logic [CMPW-1:0] w_yb_hi;

    assign w_px    = CMPW'(i_xp) + CMPW'(OFS_X);
    assign w_x_lo  = CMPW'(i_xb) + CMPW'(LO_X);
    assign w_x_hi  = CMPW'(i_xb) + CMPW'(HI_X);
    assign w_py    = CMPW'(i_yp) + CMPW'(OFS_Y);
    assign w_py_hi = w_py + CMPW'(TOL_Y);
    assign w_yb    = CMPW'(i_yb);
    assign w_yb_hi = w_yb + CMPW'(TOL_Y);

    assign o_hit = (w_px > w_x_lo) && (w_px < w_x_hi) &&
                   (w_py_hi > w_yb) && (w_py < w_yb_hi);

endmodule

// File: rtl/dt_block_scan.sv
// Scans N_BLK level blocks against the player hitbox, one block per clock,
// keeping debounced per-block touched flags and a new-touch event.
module dt_block_scan
    import dt_pkg::*;
#(
    parameter int N_BLK       = 4,
    parameter int IDXW        = 2,
    parameter int OFS_X       = DEF_OFS_X,
    parameter int LO_X        = DEF_LO_X,
    parameter int HI_X        = DEF_HI_X,
    parameter int OFS_Y       = DEF_OFS_Y,
    parameter int TOL_Y       = DEF_TOL_Y,
    parameter int HOLD_FRAMES = 1,
    parameter int STICKY      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_tick,
    input  logic [XW-1:0]         x_player,
    input  logic [YW-1:0]         y_player,
    input  logic [XW*N_BLK-1:0]   x_blocks,
    input  logic [YW*N_BLK-1:0]   y_blocks,
    input  logic [N_BLK-1:0]      block_en,
    input  logic                  clear_all,
    output logic [N_BLK-1:0]      touched,
    output logic                  touched_any,
    output logic                  busy,
    output logic                  scan_done,
    output logic                  new_touch,
    output logic [IDXW-1:0]       new_idx
);

    scan_state_t       r_state;
    scan_state_t       w_state_nxt;
    logic [IDXW-1:0]   r_idx;
    logic [IDXW-1:0]   w_idx_nxt;
    logic [XW-1:0]     r_xp;
    logic [YW-1:0]     r_yp;

    logic [N_BLK-1:0]  r_touched;
    logic [CNTW-1:0]   r_cnt [N_BLK];
    logic              r_new_touch;
    logic [IDXW-1:0]   r_new_idx;

    logic [XW-1:0]     w_xb;
    logic [YW-1:0]     w_yb;
    logic              w_en;
    logic [CNTW-1:0]   w_cnt_cur;
    logic              w_tch_cur;
    logic              w_geo_hit;
    logic              w_hit;
    logic [CNTW-1:0]   w_cnt_hit;
    logic              w_set;
    logic              w_last;

    assign w_last = (r_idx == IDXW'(N_BLK - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (frame_tick) begin
                    w_state_nxt = SCAN;
                    w_idx_nxt   = '0;
                end
            end
            SCAN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + IDXW'(1);
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Player position is frozen for the whole scan so every block sees the same probe.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && frame_tick) begin
            r_xp <= x_player;
            r_yp <= y_player;
        end
    end

    always_comb begin
        w_xb      = '0;
        w_yb      = '0;
        w_en      = 1'b0;
        w_cnt_cur = '0;
        w_tch_cur = 1'b0;
        for (int i = 0; i < N_BLK; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_xb      = x_blocks[i*XW +: XW];
                w_yb      = y_blocks[i*YW +: YW];
                w_en      = block_en[i];
                w_cnt_cur = r_cnt[i];
                w_tch_cur = r_touched[i];
            end
        end
    end

    dt_hit_cmp #(
        .OFS_X (OFS_X),
        .LO_X  (LO_X),
        .HI_X  (HI_X),
        .OFS_Y (OFS_Y),
        .TOL_Y (TOL_Y)
    ) u_cmp (
        .i_xp  (r_xp),
        .i_yp  (r_yp),
        .i_xb  (w_xb),
        .i_yb  (w_yb),
        .o_hit (w_geo_hit)
    );

    assign w_hit     = w_geo_hit && w_en;
    assign w_cnt_hit = (w_cnt_cur >= CNTW'(HOLD_FRAMES)) ? CNTW'(HOLD_FRAMES)
                                                         : w_cnt_cur + CNTW'(1);
    assign w_set     = w_hit && (w_cnt_hit >= CNTW'(HOLD_FRAMES)) && !w_tch_cur;

    // clear_all has priority over the block being evaluated in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_touched   <= '0;
            r_new_touch <= 1'b0;
            r_new_idx   <= '0;
            for (int i = 0; i < N_BLK; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_new_touch <= 1'b0;
            if (clear_all) begin
                r_touched <= '0;
                for (int i = 0; i < N_BLK; i++) begin
                    r_cnt[i] <= '0;
                end
            end else if (r_state == SCAN) begin
                for (int i = 0; i < N_BLK; i++) begin
                    if (r_idx == IDXW'(i)) begin
                        if (w_hit) begin
                            r_cnt[i] <= w_cnt_hit;
                            if (w_set) begin
                                r_touched[i] <= 1'b1;
                                r_new_touch  <= 1'b1;
                                r_new_idx    <= r_idx;
                            end
                        end else begin
                            r_cnt[i] <= '0;
                            if (STICKY == 0) begin
                                r_touched[i] <= 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

    assign touched     = r_touched;
    assign touched_any = |r_touched;
    assign busy        = (r_state != IDLE);
    assign scan_done   = (r_state == DONE);
    assign new_touch   = r_new_touch;
    assign new_idx     = r_new_idx;

endmodule

// File: tb/tb_dt_block_scan.sv
// Bench for dt_block_scan: three instances (default, HOLD_FRAMES=3, STICKY=0)
// share stimulus; a frame-level model feeds per-instance event queues.
module tb_dt_block_scan;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        clear_all = 1'b0;
    logic [9:0]  x_player = '0;
    logic [8:0]  y_player = '0;
    logic [39:0] x_blocks = '0;
    logic [35:0] y_blocks = '0;
    logic [3:0]  block_en = '0;

    logic [3:0]  tch   [3];
    logic        tany  [3];
    logic        bsy   [3];
    logic        sdone [3];
    logic        nt    [3];
    logic [1:0]  nidx  [3];

    dt_block_scan u0 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .x_player(x_player), .y_player(y_player),
        .x_blocks(x_blocks), .y_blocks(y_blocks), .block_en(block_en),
        .clear_all(clear_all), .touched(tch[0]), .touched_any(tany[0]),
        .busy(bsy[0]), .scan_done(sdone[0]), .new_touch(nt[0]), .new_idx(nidx[0])
    );

    dt_block_scan #(.HOLD_FRAMES(3), .STICKY(1)) u1 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .x_player(x_player), .y_player(y_player),
        .x_blocks(x_blocks), .y_blocks(y_blocks), .block_en(block_en),
        .clear_all(clear_all), .touched(tch[1]), .touched_any(tany[1]),
        .busy(bsy[1]), .scan_done(sdone[1]), .new_touch(nt[1]), .new_idx(nidx[1])
    );

    dt_block_scan #(.HOLD_FRAMES(1), .STICKY(0)) u2 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .x_player(x_player), .y_player(y_player),
        .x_blocks(x_blocks), .y_blocks(y_blocks), .block_en(block_en),
        .clear_all(clear_all), .touched(tch[2]), .touched_any(tany[2]),
        .busy(bsy[2]), .scan_done(sdone[2]), .new_touch(nt[2]), .new_idx(nidx[2])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    // Frame-level reference state
    int px, py;
    int bx [N];
    int by [N];
    bit ben [N];
    int m_cnt [3][N];
    bit m_tch [3][N];
    int HOLD [3] = '{1, 3, 1};
    bit STK  [3] = '{1'b1, 1'b1, 1'b0};

    int q0 [$];
    int q1 [$];
    int q2 [$];
    int nt_cnt [3] = '{0, 0, 0};
    int last_nt_cyc [3] = '{0, 0, 0};
    int last_nt_idx [3] = '{0, 0, 0};
    int mon_e;

    function automatic void chk(string name, int act, int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    function automatic bit mhit(int i);
        return ben[i] && (px + 23 > bx[i] + 2) && (px + 23 < bx[i] + 26) &&
               (py + 41 + 10 > by[i]) && (py + 41 < by[i] + 10);
    endfunction

    function automatic void push_ev(int k, int i);
        case (k)
            0: q0.push_back(i);
            1: q1.push_back(i);
            default: q2.push_back(i);
        endcase
    endfunction

    function automatic int pop_ev(int k);
        int v = -1;
        case (k)
            0: if (q0.size() > 0) v = q0.pop_front();
            1: if (q1.size() > 0) v = q1.pop_front();
            default: if (q2.size() > 0) v = q2.pop_front();
        endcase
        return v;
    endfunction

    function automatic int qsize(int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < N; i++) begin
                m_cnt[k][i] = 0;
                m_tch[k][i] = 1'b0;
            end
    endfunction

    // One frame: blocks in index order; a clear landing on block clr_at replaces its evaluation.
    function automatic void model_scan(int clr_at);
        bit h;
        for (int i = 0; i < N; i++) begin
            if (i == clr_at) begin
                model_clear();
            end else begin
                h = mhit(i);
                for (int k = 0; k < 3; k++) begin
                    if (h) begin
                        m_cnt[k][i] = (m_cnt[k][i] + 1 > HOLD[k]) ? HOLD[k] : m_cnt[k][i] + 1;
                        if (m_cnt[k][i] >= HOLD[k] && !m_tch[k][i]) begin
                            m_tch[k][i] = 1'b1;
                            push_ev(k, i);
                        end
                    end else begin
                        m_cnt[k][i] = 0;
                        if (!STK[k]) m_tch[k][i] = 1'b0;
                    end
                end
            end
        end
    endfunction

    function automatic int mt(int k);
        int v = 0;
        for (int i = 0; i < N; i++) if (m_tch[k][i]) v |= (1 << i);
        return v;
    endfunction

    function automatic int clampi(int v, int lo, int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    task automatic apply();
        x_player = px[9:0];
        y_player = py[8:0];
        for (int i = 0; i < N; i++) begin
            x_blocks[i*10 +: 10] = bx[i][9:0];
            y_blocks[i*9 +: 9]   = by[i][8:0];
            block_en[i]          = ben[i];
        end
    endtask

    task automatic do_clear();
        @(negedge clk) clear_all = 1'b1;
        @(negedge clk) clear_all = 1'b0;
        model_clear();
    endtask

    // frame_tick is driven mid-cycle; first new_touch is due 2 cycles later, scan_done N+1.
    task automatic run_scan(input int clr_at, input bit extra_tick, output int t0);
        int first_done = -1;
        int n_done = 0;
        model_scan(clr_at);
        apply();
        @(negedge clk);
        frame_tick = 1'b1;
        t0 = cyc;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            frame_tick = (extra_tick && j == 2) ? 1'b1 : 1'b0;
            clear_all  = (clr_at >= 0 && j == clr_at + 1) ? 1'b1 : 1'b0;
            if (sdone[0] === 1'b1) begin
                n_done++;
                if (first_done < 0) first_done = j;
                chk("done_sync1", int'(sdone[1]), 1);
                chk("done_sync2", int'(sdone[2]), 1);
            end
            if (j == 2) chk("busy_mid", int'(bsy[0]), 1);
        end
        chk("done_cycle", first_done, N + 1);
        chk("done_count", n_done, 1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("touched%0d", k), int'(tch[k]), mt(k));
            chk($sformatf("any%0d", k), int'(tany[k]), (mt(k) != 0) ? 1 : 0);
            chk($sformatf("evq_left%0d", k), qsize(k), 0);
            chk($sformatf("busy_end%0d", k), int'(bsy[k]), 0);
        end
    endtask

    // Monitor: every new_touch must match the next expected event of that instance.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (nt[k] === 1'b1) begin
                mon_e = pop_ev(k);
                nt_cnt[k]      = nt_cnt[k] + 1;
                last_nt_cyc[k] = cyc;
                last_nt_idx[k] = int'(nidx[k]);
                if (mon_e < 0) chk($sformatf("nt_unexpected%0d", k), 1, 0);
                else           chk($sformatf("nt_idx%0d", k), int'(nidx[k]), mon_e);
            end
        end
    end

    typedef struct { int xp; int yp; int xb; int yb; int hit; } bcase_t;
    bcase_t bcases [11] = '{
        '{79, 160, 100, 200, 0}, '{80, 160, 100, 200, 1},
        '{102, 160, 100, 200, 1}, '{103, 160, 100, 200, 0},
        // lower y edge: yp+51 > 200 first holds at yp = 150
        '{90, 149, 100, 200, 0}, '{90, 150, 100, 200, 1},
        '{90, 151, 100, 200, 1}, '{90, 168, 100, 200, 1},
        '{90, 169, 100, 200, 0}, '{90, 0, 100, 3, 0},
        '{90, 0, 100, 45, 1}
    };

    initial begin
        int t0, base, cnt;
        int pat [6] = '{1, 1, 0, 1, 1, 1};

        for (int i = 0; i < N; i++) begin
            bx[i] = 900; by[i] = 500; ben[i] = 1'b1;
        end
        px = 90; py = 160;
        model_clear();
        apply();

        repeat (2) @(negedge clk);
        chk("rst_touched", int'(tch[0]), 0);
        chk("rst_busy", int'(bsy[0]), 0);
        chk("rst_done", int'(sdone[0]), 0);
        chk("rst_nt", int'(nt[0]), 0);
        chk("rst_nidx", int'(nidx[0]), 0);
        reset = 1'b0;

        // Basic hit on block 0
        bx[0] = 100; by[0] = 200;
        run_scan(-1, 1'b0, t0);
        chk("b_tch0", int'(tch[0][0]), 1);
        chk("b_nt_lat", last_nt_cyc[0] - t0, 2);
        chk("b_nt_idx", last_nt_idx[0], 0);
        chk("b_any", int'(tany[0]), 1);

        // Boundary table, block 0 only
        for (int c = 0; c < 11; c++) begin
            do_clear();
            for (int i = 1; i < N; i++) ben[i] = 1'b0;
            px = bcases[c].xp; py = bcases[c].yp;
            bx[0] = bcases[c].xb; by[0] = bcases[c].yb; ben[0] = 1'b1;
            run_scan(-1, 1'b0, t0);
            chk($sformatf("bound%0d", c), int'(tch[0][0]), bcases[c].hit);
        end

        // Debounce on block 2
        do_clear();
        px = 90; py = 160;
        for (int i = 0; i < N; i++) begin bx[i] = 100; by[i] = 200; ben[i] = 1'b0; end
        base = nt_cnt[1];
        for (int f = 0; f < 6; f++) begin
            ben[2] = pat[f][0];
            run_scan(-1, 1'b0, t0);
            chk($sformatf("hold_f%0d", f + 1), int'(tch[1][2]), (f == 5) ? 1 : 0);
        end
        chk("hold_nt_count", nt_cnt[1] - base, 1);
        chk("hold_nt_idx", last_nt_idx[1], 2);
        ben[2] = 1'b0;
        for (int f = 0; f < 2; f++) begin
            run_scan(-1, 1'b0, t0);
            chk("hold_sticky", int'(tch[1][2]), 1);
        end

        // Reset in the middle of a scan
        for (int i = 0; i < N; i++) ben[i] = 1'b0;
        apply();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        @(negedge clk);
        chk("mid_busy_pre", int'(bsy[0]), 1);
        reset = 1'b1;
        #1;
        chk("mid_busy", int'(bsy[0]), 0);
        chk("mid_touched", int'(tch[0]), 0);
        chk("mid_any", int'(tany[0]), 0);
        chk("mid_done", int'(sdone[0]), 0);
        chk("mid_nt", int'(nt[0]), 0);
        chk("mid_nidx", int'(nidx[0]), 0);
        @(negedge clk) reset = 1'b0;
        model_clear();
        cnt = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (sdone[0] === 1'b1 || bsy[0] === 1'b1) cnt++;
        end
        chk("mid_no_resume", cnt, 0);

        // Non-sticky fall on block 1
        do_clear();
        ben[1] = 1'b1;
        base = nt_cnt[2];
        run_scan(-1, 1'b0, t0);
        chk("nst_set", int'(tch[2][1]), 1);
        ben[1] = 1'b0;
        run_scan(-1, 1'b0, t0);
        chk("nst_fall", int'(tch[2][1]), 0);
        chk("nst_nt_count", nt_cnt[2] - base, 1);

        // frame_tick while busy, then clear_all on block 0's evaluation cycle
        ben[1] = 1'b1;
        run_scan(-1, 1'b1, t0);
        do_clear();
        ben[1] = 1'b0; ben[0] = 1'b1;
        base = nt_cnt[0];
        run_scan(0, 1'b0, t0);
        chk("clr_tch0", int'(tch[0][0]), 0);
        chk("clr_no_nt", nt_cnt[0] - base, 0);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 7) == 0) do_clear();
            px = $urandom_range(0, 980);
            py = $urandom_range(0, 450);
            for (int i = 0; i < N; i++) begin
                bx[i]  = clampi(px + int'($urandom_range(0, 26)) - 4, 0, 1023);
                by[i]  = clampi(py + 30 + int'($urandom_range(0, 22)), 0, 511);
                ben[i] = ($urandom_range(0, 4) != 0);
            end
            run_scan(($urandom_range(0, 7) == 0) ? int'($urandom_range(0, N - 1)) : -1,
                     ($urandom_range(0, 5) == 0), t0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
